pc_ir_unit: RTL and testbench
=============================

Name: pc_ir_unit

Overview:
- Front-end register stage of the multicycle MIPS datapath, directly downstream of the multicycle controller; consumes its pc_write, pc_write_condition, pcsrc, IorD and IR_write outputs.
- Holds the PC, IR, MDR and ALUOut registers. Resolves the beq/bne branch condition from zero. Drives the unified memory address and the decoded instruction fields.
- Also keeps a sticky misalignment flag and a fetched-instruction counter for debug and verification.

Parameters:
WIDTH, 32, datapath width in bits
RESET_PC, 32'h0000_0000, PC value after reset
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (reset==0 resets the block)
pc_write  in  1  unconditional PC load
pc_write_condition  in  1  conditional PC load (branch)
pcsrc  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 rs_data
IorD  in  1  memory address select: 0 PC, 1 alu_out
IR_write  in  1  load IR from mem_rdata
zero  in  1  ALU zero flag for the current cycle
alu_result  in  WIDTH  combinational ALU output
rs_data  in  WIDTH  register-file A value (jr target)
mem_rdata  in  WIDTH  memory read data
mem_addr  out  WIDTH  memory address
pc  out  WIDTH  current PC register
ir  out  WIDTH  instruction register
opcode  out  6  ir[31:26]
funct  out  6  ir[5:0]
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
imm_sext  out  WIDTH  sign-extended ir[15:0]
mdr  out  WIDTH  memory data register
alu_out  out  WIDTH  ALUOut register
misalign_err  out  1  sticky: a PC load had nonzero bits [1:0]
instr_count  out  CNT_W  number of IR loads since reset

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC, ir=0, mdr=0, alu_out=0, misalign_err=0, instr_count=0. Release is synchronous to the next clk edge.
- alu_out <= alu_result on every rising edge.
- mdr <= mem_rdata on every rising edge.
- IR_write=1: ir <= mem_rdata and instr_count <= instr_count+1 (wraps modulo 2^CNT_W, no saturation).
- IR_write=0: ir and instr_count hold.
- mem_addr combinational: IorD ? alu_out : pc.
- Jump target = {pc[31:28], ir[25:0], 2'b00}. The pc used is the already-incremented PC at the time of the jump cycle.
- is_bne = (ir[31:26]==6'b000101).
- take = pc_write | (pc_write_condition & (zero ^ is_bne)).
  - beq branches on zero=1.
  - bne branches on zero=0.
  - Any other opcode with pc_write_condition behaves as beq.
- take=1: next = mux(pcsrc); pc <= {next[31:2], 2'b00}. If next[1:0]!=0, misalign_err <= 1, held until reset.
- take=0: pc holds. pcsrc is ignored.
- pc_write and pc_write_condition both 1: pc_write wins (unconditional load).
- IR_write and a PC load in the same cycle (fetch): both happen. ir captures mem_rdata addressed by the old pc.
- Output latency: all decoded fields are combinational from ir, valid the cycle after IR_write.
- The controller drives the link value for jal separately; this block makes no register-file writes.
- Reset asserted mid-instruction: all registers clear immediately. The first post-reset fetch uses RESET_PC.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants: OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_BEQ 6'h04, OP_BNE 6'h05, OP_ADDI 6'h08, OP_ANDI 6'h0C, OP_LW 6'h23, OP_SW 6'h2B
  - pcsrc encodings: PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RS
- One natural sub-module: branch_resolve. It is combinational; inputs pc_write, pc_write_condition, zero, opcode; output take. Keeps the condition logic unit-testable.

Test Plan:
- Reset with reset=0 while pc=0x40 -> pc=0x0, ir=0, instr_count=0 immediately, without waiting for a clock edge.
- Fetch: pc=0, mem_rdata=0x8C22_0004, IR_write=1, pc_write=1, pcsrc=00, alu_result=4 -> after edge ir=0x8C220004, rt=2, imm_sext=4, pc=4, instr_count=1.
- beq taken/not: ir opcode 0x04, pc_write_condition=1, pcsrc=01, alu_out=0x20. zero=1 -> pc=0x20; zero=0 -> pc holds.
- bne: ir opcode 0x05, zero=0 -> pc=alu_out; zero=1 -> pc holds.
- Jump: pc=0x1000_0004, ir=0x0800_0010, pc_write=1, pcsrc=10 -> pc=0x1000_0040.
- jr: pcsrc=11, rs_data=0x0000_0106 -> pc=0x104 and misalign_err=1, still 1 after a further aligned load. IorD=1 with alu_out=0x80 -> mem_addr=0x80.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS front end:
// opcode values and next-PC source encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RS     = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/pc_ir_unit_branch_resolve.sv
// Decides whether the PC is loaded this cycle.
// Ports: pc_write, pc_write_condition, zero, opcode -> take.
import mips_pkg::*;

module branch_resolve (
    input  logic       pc_write,
    input  logic       pc_write_condition,
    input  logic       zero,
    input  logic [5:0] opcode,
    output logic       take
);

    logic w_is_bne;

    // bne inverts the zero sense; every other opcode acts as beq
    assign w_is_bne = (opcode == OP_BNE);
    assign take     = pc_write | (pc_write_condition & (zero ^ w_is_bne));

endmodule

// File: rtl/pc_ir_unit.sv
// PC, IR, MDR and ALUOut registers of the multicycle MIPS datapath,
// with branch resolve, memory address mux, field decode and debug state.
// Inputs: controller strobes (pc_write, pc_write_condition, pcsrc, IorD,
//   IR_write), zero, alu_result, rs_data, mem_rdata.
// Outputs: mem_addr, pc, ir + decoded fields, mdr, alu_out,
//   misalign_err (sticky), instr_count.
import mips_pkg::*;

module pc_ir_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             pc_write_condition,
    input  logic [1:0]       pcsrc,
    input  logic             IorD,
    input  logic             IR_write,
    input  logic             zero,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] imm_sext,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] alu_out,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instr_count
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic             w_take;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_jump;

    branch_resolve u_branch (
        .pc_write           (pc_write),
        .pc_write_condition (pc_write_condition),
        .zero               (zero),
        .opcode             (r_ir[31:26]),
        .take               (w_take)
    );

    // Jump uses the PC already advanced during fetch
    assign w_jump = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};

    always_comb begin
        w_next = alu_result;
        unique case (pcsrc)
            PCSRC_ALU:    w_next = alu_result;
            PCSRC_ALUOUT: w_next = r_alu_out;
            PCSRC_JUMP:   w_next = w_jump;
            PCSRC_RS:     w_next = rs_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= WIDTH'(RESET_PC);
            r_ir       <= '0;
            r_mdr      <= '0;
            r_alu_out  <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_alu_out <= alu_result;
            r_mdr     <= mem_rdata;
            if (IR_write) begin
                r_ir  <= mem_rdata;
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_take) begin
                // Low bits are forced to word alignment; a
                // nonzero request is remembered until reset
                r_pc <= {w_next[WIDTH-1:2], 2'b00};
                if (w_next[1:0] != 2'b00)
                    r_misalign <= 1'b1;
            end
        end
    end

    assign mem_addr     = IorD ? r_alu_out : r_pc;
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign opcode       = r_ir[31:26];
    assign rs           = r_ir[25:21];
    assign rt           = r_ir[20:16];
    assign rd           = r_ir[15:11];
    assign funct        = r_ir[5:0];
    assign imm_sext     = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    assign mdr          = r_mdr;
    assign alu_out      = r_alu_out;
    assign misalign_err = r_misalign;
    assign instr_count  = r_cnt;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus a
// randomized run against a behavioural model of the register stage.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        pc_write_condition;
    logic [1:0]  pcsrc;
    logic        IorD;
    logic        IR_write;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rs_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic        misalign_err;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_pc, m_ir, m_mdr, m_aout, m_cnt;
    logic        m_err;

    pc_ir_unit dut (
        .clk                (clk),
        .reset              (reset),
        .pc_write           (pc_write),
        .pc_write_condition (pc_write_condition),
        .pcsrc              (pcsrc),
        .IorD               (IorD),
        .IR_write           (IR_write),
        .zero               (zero),
        .alu_result         (alu_result),
        .rs_data            (rs_data),
        .mem_rdata          (mem_rdata),
        .mem_addr           (mem_addr),
        .pc                 (pc),
        .ir                 (ir),
        .opcode             (opcode),
        .funct              (funct),
        .rs                 (rs),
        .rt                 (rt),
        .rd                 (rd),
        .imm_sext           (imm_sext),
        .mdr                (mdr),
        .alu_out            (alu_out),
        .misalign_err       (misalign_err),
        .instr_count        (instr_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        pc_write = 0; pc_write_condition = 0; pcsrc = 0;
        IorD = 0; IR_write = 0; zero = 0;
        alu_result = 0; rs_data = 0; mem_rdata = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mdr = 0; m_aout = 0; m_cnt = 0; m_err = 0;
    endtask

    // One clock: predict from current inputs, clock, then commit.
    task automatic step();
        logic        take;
        logic        is_bne;
        logic [31:0] target;
        is_bne = (m_ir[31:26] == 6'h05);
        if (pc_write)
            take = 1;
        else if (pc_write_condition)
            take = is_bne ? !zero : zero;
        else
            take = 0;
        case (pcsrc)
            2'd0:    target = alu_result;
            2'd1:    target = m_aout;
            2'd2:    target = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: target = rs_data;
        endcase
        @(posedge clk);
        #1;
        if (take) begin
            m_pc = target & 32'hFFFF_FFFC;
            if (target % 4 != 0) m_err = 1;
        end
        if (IR_write) begin
            m_ir  = mem_rdata;
            m_cnt = m_cnt + 1;
        end
        m_mdr  = mem_rdata;
        m_aout = alu_result;
    endtask

    task automatic test_reset();
        idle_inputs();
        pc_write = 1; alu_result = 32'h40;
        IR_write = 1; mem_rdata = 32'h1234_5678;
        step();
        checks++;
        if (pc !== 32'h40) begin
            errors++; $display("FAIL preload_pc got %h want %h", pc, 32'h40);
        end
        idle_inputs();
        #2 reset = 0;
        #1;
        checks++;
        if (pc !== 0 || ir !== 0 || instr_count !== 0) begin
            errors++;
            $display("FAIL async_reset got pc=%h ir=%h cnt=%0d want 0/0/0",
                     pc, ir, instr_count);
        end
        checks++;
        if (mdr !== 0 || alu_out !== 0 || misalign_err !== 0) begin
            errors++;
            $display("FAIL async_reset_aux got mdr=%h aout=%h err=%b want 0",
                     mdr, alu_out, misalign_err);
        end
        #3 reset = 1;
        model_reset();
    endtask

    task automatic test_fetch();
        idle_inputs();
        IR_write = 1; pc_write = 1; pcsrc = 2'b00;
        alu_result = 32'd4; mem_rdata = 32'h8C22_0004;
        #1;
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++; $display("FAIL fetch_addr got %h want 0", mem_addr);
        end
        step();
        checks++;
        if (ir !== 32'h8C22_0004 || rt !== 5'd2 || imm_sext !== 32'd4) begin
            errors++;
            $display("FAIL fetch_ir got ir=%h rt=%0d imm=%h want 8c220004/2/4",
                     ir, rt, imm_sext);
        end
        checks++;
        if (pc !== 32'd4 || instr_count !== 32'd1 || opcode !== 6'h23) begin
            errors++;
            $display("FAIL fetch_pc got pc=%h cnt=%0d op=%h want 4/1/23",
                     pc, instr_count, opcode);
        end
    endtask

    task automatic test_branch();
        logic [31:0] hold;
        // beq: load opcode 0x04 and ALUOut 0x20
        idle_inputs();
        IR_write = 1; mem_rdata = 32'h1000_0008; alu_result = 32'h20;
        step();
        hold = pc;
        IR_write = 0; pc_write_condition = 1; pcsrc = 2'b01; zero = 0;
        step();
        checks++;
        if (pc !== m_pc || pc !== hold) begin
            errors++; $display("FAIL beq_not_taken got %h want %h", pc, m_pc);
        end
        zero = 1;
        step();
        checks++;
        if (pc !== 32'h20) begin
            errors++; $display("FAIL beq_taken got %h want %h", pc, 32'h20);
        end
        // bne: opcode 0x05, ALUOut 0x44
        idle_inputs();
        IR_write = 1; mem_rdata = 32'h1400_0010; alu_result = 32'h44;
        step();
        IR_write = 0; pc_write_condition = 1; pcsrc = 2'b01; zero = 1;
        step();
        checks++;
        if (pc !== 32'h20) begin
            errors++; $display("FAIL bne_not_taken got %h want %h", pc, 32'h20);
        end
        zero = 0;
        step();
        checks++;
        if (pc !== 32'h44) begin
            errors++; $display("FAIL bne_taken got %h want %h", pc, 32'h44);
        end
        // unconditional load overrides a failing bne condition
        zero = 1; pc_write = 1; pcsrc = 2'b00; alu_result = 32'h88;
        step();
        checks++;
        if (pc !== 32'h88) begin
            errors++; $display("FAIL pc_write_wins got %h want %h", pc, 32'h88);
        end
    endtask

    task automatic test_jump();
        idle_inputs();
        IR_write = 1; mem_rdata = 32'h0800_0010;
        pc_write = 1; alu_result = 32'h1000_0004;
        step();
        IR_write = 0; pcsrc = 2'b10; alu_result = 0;
        step();
        checks++;
        if (pc !== 32'h1000_0040) begin
            errors++; $display("FAIL jump got %h want %h", pc, 32'h1000_0040);
        end
    endtask

    task automatic test_jr();
        idle_inputs();
        pc_write = 1; pcsrc = 2'b11; rs_data = 32'h0000_0106;
        step();
        checks++;
        if (pc !== 32'h104 || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL jr_misalign got pc=%h err=%b want 104/1",
                     pc, misalign_err);
        end
        pcsrc = 2'b00; alu_result = 32'h200;
        step();
        checks++;
        if (pc !== 32'h200 || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got pc=%h err=%b want 200/1",
                     pc, misalign_err);
        end
        idle_inputs();
        alu_result = 32'h80;
        step();
        IorD = 1;
        #1;
        checks++;
        if (mem_addr !== 32'h80) begin
            errors++; $display("FAIL iord_addr got %h want %h", mem_addr, 32'h80);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        ops[0] = 6'h04; ops[1] = 6'h05; ops[2] = 6'h02;
        ops[3] = 6'h23; ops[4] = 6'h00; ops[5] = 6'h08;
        for (int i = 0; i < 400; i++) begin
            pc_write           = ($urandom_range(0, 3) == 0);
            pc_write_condition = $urandom_range(0, 1);
            pcsrc              = 2'($urandom_range(0, 3));
            IorD               = $urandom_range(0, 1);
            IR_write           = $urandom_range(0, 1);
            zero               = $urandom_range(0, 1);
            alu_result         = $urandom;
            if ($urandom_range(0, 3) != 0) alu_result[1:0] = 2'b00;
            rs_data            = $urandom;
            if ($urandom_range(0, 3) != 0) rs_data[1:0] = 2'b00;
            mem_rdata          = $urandom;
            mem_rdata[31:26]   = ops[$urandom_range(0, 5)];
            step();
            checks++;
            if (pc !== m_pc || ir !== m_ir || instr_count !== m_cnt) begin
                errors++;
                $display("FAIL rand_core[%0d] got pc=%h ir=%h cnt=%0d want %h %h %0d",
                         i, pc, ir, instr_count, m_pc, m_ir, m_cnt);
            end
            checks++;
            if (mdr !== m_mdr || alu_out !== m_aout || misalign_err !== m_err) begin
                errors++;
                $display("FAIL rand_aux[%0d] got mdr=%h aout=%h err=%b want %h %h %b",
                         i, mdr, alu_out, misalign_err, m_mdr, m_aout, m_err);
            end
            checks++;
            if (mem_addr !== (IorD ? m_aout : m_pc)) begin
                errors++;
                $display("FAIL rand_addr[%0d] got %h want %h",
                         i, mem_addr, IorD ? m_aout : m_pc);
            end
            checks++;
            if (opcode !== m_ir[31:26] || rs !== m_ir[25:21] ||
                rt !== m_ir[20:16] || rd !== m_ir[15:11] ||
                funct !== m_ir[5:0] ||
                $signed(imm_sext) !== 32'(signed'(m_ir[15:0]))) begin
                errors++;
                $display("FAIL rand_fields[%0d] got op=%h imm=%h want op=%h ir=%h",
                         i, opcode, imm_sext, m_ir[31:26], m_ir);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        model_reset();
        #12 reset = 1;
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_jr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
